// File: rtl/snn_noc_pkg.sv
// NOC packet fields, type codes, packet struct and builders shared by the NOC nodes.
package snn_noc_pkg;

    localparam int unsigned NOC_W     = 34;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned TYP_W     = 2;
    localparam int unsigned PAYLOAD_W = 24;
    localparam int unsigned SRC_LSB   = 30;
    localparam int unsigned DST_LSB   = 26;
    localparam int unsigned TYP_LSB   = 24;

    localparam logic [TYP_W-1:0]  TYP_PSUM   = 2'b00;
    localparam logic [TYP_W-1:0]  TYP_KERNEL = 2'b01;
    localparam logic [TYP_W-1:0]  TYP_MEM    = 2'b10;
    localparam logic [TYP_W-1:0]  TYP_OUT    = 2'b11;
    localparam logic [ADDR_W-1:0] DONE_CODE  = 4'b1111;

    typedef struct packed {
        logic [ADDR_W-1:0]    src;
        logic [ADDR_W-1:0]    dst;
        logic [TYP_W-1:0]     typ;
        logic [PAYLOAD_W-1:0] payload;
    } noc_pkt_t;

    function automatic noc_pkt_t build_spike_pkt(input logic [ADDR_W-1:0] s,
                                                 input logic [ADDR_W-1:0] d,
                                                 input logic [1:0]        row,
                                                 input logic [1:0]        col);
        build_spike_pkt = '{src: s, dst: d, typ: TYP_OUT, payload: {20'b0, row, col}};
    endfunction

    // Caller zero-extends the potential into the payload field.
    function automatic noc_pkt_t build_mem_pkt(input logic [ADDR_W-1:0]    s,
                                               input logic [ADDR_W-1:0]    d,
                                               input logic [PAYLOAD_W-1:0] pot);
        build_mem_pkt = '{src: s, dst: d, typ: TYP_MEM, payload: pot};
    endfunction

endpackage

// File: rtl/snn_potential_adder_if.sv
// Valid/ready NOC link; master drives valid/data, slave drives ready.
interface snn_potential_adder_if
    import snn_noc_pkg::*;
#(
    parameter int unsigned W = NOC_W
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/snn_noc_out_reg.sv
// One-entry registered valid/ready output stage; data held while stalled.
module snn_noc_out_reg #(
    parameter int unsigned W = 34
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_valid,
    input  logic [W-1:0]         load_data,
    output logic                 load_ready_c,
    snn_potential_adder_if.master out_noc
);
    logic         valid_q;
    logic [W-1:0] data_q;

    assign load_ready_c  = !valid_q || out_noc.ready;
    assign out_noc.valid = valid_q;
    assign out_noc.data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_ready_c) begin
            valid_q <= load_valid;
            if (load_valid) data_q <= load_data;
        end
    end
endmodule

// File: rtl/snn_potential_adder.sv
// Output-neuron accumulator: psums + residual -> saturate -> threshold -> spike/mem packets.
// Optional LEAK_EN macro subtracts LEAK (floored at 0) before thresholding.
module snn_potential_adder
    import snn_noc_pkg::*;
#(
    parameter int unsigned          WIDTH_NOC    = 34,
    parameter logic [3:0]           NODE_ADDR    = 4'b0001,
    parameter logic [3:0]           WRAPPER_ADDR = 4'b0000,
    parameter logic [1:0]           COL_IDX      = 2'd0,
    parameter int unsigned          OFX          = 3,
    parameter int unsigned          NUM_PSUM     = 3,
    parameter int unsigned          POT_WIDTH    = 8,
    parameter logic [POT_WIDTH-1:0] THRESHOLD    = 8'd64,
    parameter logic [POT_WIDTH-1:0] LEAK         = 8'd1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    snn_potential_adder_if.slave  in_noc,
    snn_potential_adder_if.master out_noc,
    input  logic                  first_ts,
    output logic                  busy
);
    localparam int unsigned ACC_W = POT_WIDTH + 2;
    localparam int unsigned CNT_W = $clog2(NUM_PSUM + 1);
    localparam int unsigned ROW_W = 2;

    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_WAIT_MEM, S_FIRE, S_SEND_SPIKE, S_SEND_MEM
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   res_q, res_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic                   spike_q, spike_d;
    logic [POT_WIDTH-1:0]   newpot_q, newpot_d;
    logic                   drain_q, drain_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;

    noc_pkt_t               in_pkt;
    logic                   in_fire;
    logic [POT_WIDTH-1:0]   operand;
    logic [POT_WIDTH-1:0]   sat_c, pot_c;
    logic                   load_valid, load_ready_c;
    logic [WIDTH_NOC-1:0]   load_data;
    logic                   unused_bits;

    assign in_pkt        = in_noc.data;
    assign in_fire       = in_noc.valid && in_ready_q && (in_pkt.dst == NODE_ADDR);
    assign operand       = in_pkt.payload[POT_WIDTH-1:0];
    assign in_noc.ready  = in_ready_q;
    assign busy          = busy_q;

    // Clamp the wide accumulator so the new potential always fits POT_WIDTH.
    assign sat_c = (acc_q > ACC_W'({POT_WIDTH{1'b1}})) ? '1 : acc_q[POT_WIDTH-1:0];
`ifdef LEAK_EN
    assign pot_c       = (sat_c >= LEAK) ? sat_c - LEAK : '0;
    assign unused_bits = ^{in_pkt.src, in_pkt.payload[PAYLOAD_W-1:POT_WIDTH]};
`else
    assign pot_c       = sat_c;
    assign unused_bits = ^{in_pkt.src, in_pkt.payload[PAYLOAD_W-1:POT_WIDTH], LEAK};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            res_q      <= 1'b0;
            row_q      <= '0;
            spike_q    <= 1'b0;
            newpot_q   <= '0;
            drain_q    <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            row_q      <= row_d;
            spike_q    <= spike_d;
            newpot_q   <= newpot_d;
            drain_q    <= drain_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        row_d      = row_q;
        spike_d    = spike_q;
        newpot_d   = newpot_q;
        drain_d    = drain_q;
        load_valid = 1'b0;
        load_data  = '0;

        // Busy lingers until the mem packet of the pixel leaves the output stage.
        if (drain_q && out_noc.valid && out_noc.ready) drain_d = 1'b0;

        case (state_q)
            S_IDLE, S_ACCUM, S_WAIT_MEM: begin
                if (in_fire && in_pkt.typ == TYP_PSUM && cnt_q < CNT_W'(NUM_PSUM)) begin
                    acc_d = acc_q + ACC_W'(operand);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_PSUM - 1))
                        state_d = (first_ts || res_q) ? S_FIRE : S_WAIT_MEM;
                    else
                        state_d = S_ACCUM;
                end else if (in_fire && in_pkt.typ == TYP_MEM && !res_q) begin
                    acc_d = acc_q + ACC_W'(operand);
                    res_d = 1'b1;
                    if (state_q == S_WAIT_MEM) state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                spike_d  = (pot_c >= THRESHOLD);
                newpot_d = spike_d ? pot_c - THRESHOLD : pot_c;
                acc_d    = '0;
                cnt_d    = '0;
                res_d    = 1'b0;
                state_d  = spike_d ? S_SEND_SPIKE : S_SEND_MEM;
            end
            S_SEND_SPIKE: begin
                load_valid = 1'b1;
                load_data  = build_spike_pkt(NODE_ADDR, WRAPPER_ADDR, row_q, COL_IDX);
                if (load_ready_c) state_d = S_SEND_MEM;
            end
            S_SEND_MEM: begin
                load_valid = 1'b1;
                load_data  = build_mem_pkt(NODE_ADDR, WRAPPER_ADDR, PAYLOAD_W'(newpot_q));
                if (load_ready_c) begin
                    row_d   = (row_q == ROW_W'(OFX - 1)) ? '0 : row_q + ROW_W'(1);
                    drain_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE) || (state_d == S_ACCUM) || (state_d == S_WAIT_MEM);
        busy_d     = (state_d != S_IDLE) || drain_d;
    end

    snn_noc_out_reg #(.W(WIDTH_NOC)) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready_c (load_ready_c),
        .out_noc      (out_noc)
    );
endmodule

// File: tb/tb_snn_potential_adder.sv
// Directed + randomized bench for snn_potential_adder with a pixel-level reference model.
module tb_snn_potential_adder;
    localparam logic [1:0] COL = 2'd0;

    logic clk;
    logic rst_n;
    logic first_ts;
    logic busy;

    snn_potential_adder_if in_if ();
    snn_potential_adder_if out_if ();

    snn_potential_adder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_noc   (in_if),
        .out_noc  (out_if),
        .first_ts (first_ts),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int row_m  = 0;
    logic [33:0] cap_q[$];
    logic [33:0] exp_q[$];

    always @(negedge clk)
        if (rst_n === 1'b1 && out_if.valid === 1'b1 && out_if.ready === 1'b1)
            cap_q.push_back(out_if.data);

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] out_pkt(input logic [1:0] typ, input logic [23:0] pl);
        return {4'b0001, 4'b0000, typ, pl};
    endfunction

    function automatic logic [33:0] in_pkt(input logic [3:0] dst, input logic [1:0] typ, input int v);
        return {4'h5, dst, typ, 16'h0, 8'(v)};
    endfunction

    // Pixel model: sum, clamp to 255, optional leak, threshold 64.
    function automatic int model_pot(input int sum, output bit spk);
        int s;
        s = (sum > 255) ? 255 : sum;
`ifdef LEAK_EN
        s = (s >= 1) ? s - 1 : 0;
`endif
        spk = (s >= 64);
        return spk ? s - 64 : s;
    endfunction

    task automatic send(input logic [33:0] p);
        int n = 0;
        in_if.valid = 1'b1;
        in_if.data  = p;
        do begin
            @(negedge clk);
            n++;
        end while (in_if.ready !== 1'b1 && n < 100);
        if (in_if.ready !== 1'b1) check("send_timeout", in_if.ready, 1'b1);
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_if.ready, 1'b1);
        check({tag, "_out_valid"}, out_if.valid, 1'b0);
        check({tag, "_out_data"}, out_if.data, 34'h0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        row_m = 0;
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic pixel(input string tag, input int p0, input int p1, input int p2, input int res,
                         input bit ts, input bit early, input bit dup, input bit junk, input int stall);
        bit spk;
        int pot, n;
        logic [33:0] hold;
        first_ts = ts;
        pot = model_pot(p0 + p1 + p2 + (ts ? 0 : res), spk);
        if (spk) exp_q.push_back(out_pkt(2'b11, {20'b0, 2'(row_m), COL}));
        exp_q.push_back(out_pkt(2'b10, 24'(pot)));
        if (stall > 0) out_if.ready = 1'b0;
        if (junk) begin
            send(in_pkt(4'b0010, 2'b00, 99));
            send(in_pkt(4'b0001, 2'b01, 77));
        end
        if (!ts && early) begin
            send(in_pkt(4'b0001, 2'b10, res));
            if (dup) send(in_pkt(4'b0001, 2'b10, 50));
        end
        send(in_pkt(4'b0001, 2'b00, p0));
        check({tag, "_busy_hi"}, busy, 1'b1);
        send(in_pkt(4'b0001, 2'b00, p1));
        send(in_pkt(4'b0001, 2'b00, p2));
        if (!ts && !early) send(in_pkt(4'b0001, 2'b10, res));
        check({tag, "_fire_rdy"}, in_if.ready, 1'b0);
        @(posedge clk); #1;
        check({tag, "_lat1"}, out_if.valid, 1'b0);
        @(posedge clk); #1;
        check({tag, "_lat2"}, out_if.valid, 1'b1);
        if (stall > 0) begin
            hold = out_if.data;
            repeat (stall) begin
                @(posedge clk); #1;
                check({tag, "_stall_data"}, out_if.data, hold);
                check({tag, "_stall_rdy"}, in_if.ready, spk ? 1'b0 : 1'b1);
            end
            out_if.ready = 1'b1;
        end
        n = 0;
        while (cap_q.size() < exp_q.size() && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        check({tag, "_npkt"}, 34'(cap_q.size()), 34'(exp_q.size()));
        while (cap_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_pkt"}, cap_q.pop_front(), exp_q.pop_front());
        check({tag, "_busy_lo"}, busy, 1'b0);
        cap_q.delete();
        exp_q.delete();
        row_m = (row_m + 1) % 3;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit spk;
        int pot, n;
        rst_n        = 1'b0;
        first_ts     = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;
        #7 check_reset_outputs("init");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        pixel("t1_nospike", 20, 30, 10, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        do_reset();
        pixel("t2_resid", 40, 20, 10, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        pixel("t3_thresh", 0, 0, 0, 64, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        pixel("t4_sat", 200, 200, 200, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        pixel("t5_stall", 50, 10, 10, 0, 1'b1, 1'b0, 1'b0, 1'b1, 5);
        pixel("t5_row1", 30, 30, 30, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        pixel("t5_row2", 64, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        pixel("t5_wrap", 1, 1, 100, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Asynchronous reset after two psums, then a fresh pixel needs all three.
        first_ts = 1'b1;
        send(in_pkt(4'b0001, 2'b00, 10));
        send(in_pkt(4'b0001, 2'b00, 10));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        row_m = 0;
        cap_q.delete();
        send(in_pkt(4'b0001, 2'b00, 10));
        send(in_pkt(4'b0001, 2'b00, 10));
        repeat (4) @(posedge clk);
        #1;
        check("midrst_partial_valid", out_if.valid, 1'b0);
        check("midrst_partial_cnt", 34'(cap_q.size()), 34'd0);
        send(in_pkt(4'b0001, 2'b00, 10));
        pot = model_pot(30, spk);
        n = 0;
        while (cap_q.size() < 1 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        check("midrst_npkt", 34'(cap_q.size()), 34'd1);
        if (cap_q.size() > 0) check("midrst_pkt", cap_q.pop_front(), out_pkt(2'b10, 24'(pot)));
        cap_q.delete();
        row_m = 1;

        for (int i = 0; i < 10; i++) begin
            pixel("rnd",
                  ($urandom % 3 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40)),
                  int'($urandom_range(0, 40)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)),
                  1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
                  int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
